// File: rtl/implication_responder.sv
// rtl/implication_responder.sv - drives a consequent pulse a programmable number of cycles after each antecedent
module implication_responder #(
    parameter int MAX_LATENCY = 8,
    parameter int DEPTH       = 4,
    parameter int LAT_W       = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             antecedent,
    input  logic [LAT_W-1:0] latency,
    input  logic             drop_next,
    output logic             consequent,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             drop_armed,
    output logic             overflow,
    output logic             collision
);

    logic [MAX_LATENCY-1:0] sr_q, sr_d;
    logic [MAX_LATENCY-1:0] shifted;
    logic [MAX_LATENCY-1:0] target;
    logic [LAT_W-1:0]       lat_eff;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   drop_armed_q, drop_armed_d;
    logic                   overflow_q, collision_q;
    logic                   req_zero, req_sched, accept, reject, merge;
    logic                   raw_due, drop_eff;

    always_comb begin
        lat_eff   = (latency > LAT_W'(MAX_LATENCY)) ? LAT_W'(MAX_LATENCY) : latency;
        req_zero  = antecedent && (lat_eff == '0);
        req_sched = antecedent && (lat_eff != '0);
        // Admission uses the pre-edge count, so a slot freed this cycle is not reusable yet.
        accept    = req_sched && (cnt_q < CNT_W'(DEPTH));
        reject    = req_sched && !(cnt_q < CNT_W'(DEPTH));

        target = '0;
        for (int i = 0; i < MAX_LATENCY; i++) begin
            target[i] = (lat_eff == LAT_W'(i + 1));
        end

        shifted = sr_q >> 1;
        merge   = accept && ((shifted & target) != '0);
        sr_d    = accept ? (shifted | target) : shifted;

        cnt_d = '0;
        for (int i = 0; i < MAX_LATENCY; i++) begin
            cnt_d = cnt_d + CNT_W'(sr_d[i]);
        end

        raw_due  = sr_q[0] | req_zero;
        drop_eff = drop_armed_q | drop_next;

        // Consuming a due response takes priority over arming a new drop.
        drop_armed_d = drop_armed_q;
        if (raw_due && drop_eff) begin
            drop_armed_d = 1'b0;
        end else if (drop_next) begin
            drop_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            drop_armed_q <= 1'b0;
            overflow_q   <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            drop_armed_q <= drop_armed_d;
            overflow_q   <= overflow_q | reject;
            collision_q  <= collision_q | merge;
        end
    end

    // The zero-latency path is combinational; hold it low while reset is asserted.
    assign consequent  = rst_n & raw_due & ~drop_eff;
    assign pending_cnt = cnt_q;
    assign drop_armed  = drop_armed_q;
    assign overflow    = overflow_q;
    assign collision   = collision_q;

endmodule
